// File: rtl/icache_refill_ctrl_pkg.sv
// Shared types and constants for the instruction-cache refill engine.
package icache_refill_ctrl_pkg;

    localparam int IFR_ADDR_W     = 32;
    localparam int IFR_WORD_BYTES = 4;
    localparam int IFR_CNT_W      = 3;

    typedef enum logic [1:0] {
        IFR_IDLE = 2'd0,
        IFR_REQ  = 2'd1,
        IFR_READ = 2'd2,
        IFR_WB   = 2'd3
    } ifr_state_e;

    // The final READ cycle keeps presenting the last byte address.
    function automatic logic [1:0] byteOffset(input logic [IFR_CNT_W-1:0] cnt);
        return (cnt >= IFR_CNT_W'(IFR_WORD_BYTES)) ? 2'd3 : cnt[1:0];
    endfunction

endpackage

// File: rtl/icache_refill_ctrl_if.sv
// Miss, RAM-port and refill-write signals between the icache, arbiter and refill engine.
interface icache_refill_ctrl_if #(
    parameter int ADDR_W = icache_refill_ctrl_pkg::IFR_ADDR_W
);

    logic              rdy_in;
    logic              miss_valid_in;
    logic [ADDR_W-1:0] miss_addr_in;
    logic              flush_in;
    logic              mem_gnt_in;
    logic [7:0]        mem_din;
    logic              mem_req_out;
    logic [ADDR_W-1:0] mem_a;
    logic              mem_wr;
    logic [31:0]       refill_data_out;
    logic              refill_we_out;
    logic              busy_out;

    modport slave (
        input  rdy_in, miss_valid_in, miss_addr_in, flush_in, mem_gnt_in, mem_din,
        output mem_req_out, mem_a, mem_wr, refill_data_out, refill_we_out, busy_out
    );

    modport master (
        output rdy_in, miss_valid_in, miss_addr_in, flush_in, mem_gnt_in, mem_din,
        input  mem_req_out, mem_a, mem_wr, refill_data_out, refill_we_out, busy_out
    );

endinterface

// File: rtl/icache_refill_ctrl.sv
// Refill engine: fetches four bytes of a missed instruction word from the byte RAM
// and hands the little-endian word to the icache with a single write pulse.
module icache_refill_ctrl
    import icache_refill_ctrl_pkg::*;
#(
    parameter int ADDR_W = IFR_ADDR_W
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    icache_refill_ctrl_if.slave  bus
);

    localparam logic [IFR_CNT_W-1:0] CNT_LAST = IFR_CNT_W'(IFR_WORD_BYTES);

    ifr_state_e           state_q, state_d;
    logic [IFR_CNT_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0]    base_q, base_d;
    logic [31:0]          data_q, data_d;
    logic [31:0]          word_q, word_d;

    logic                 memReq;
    logic [ADDR_W-1:0]    memA;
    logic                 refillWe;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= IFR_IDLE;
            cnt_q   <= '0;
            base_q  <= '0;
            data_q  <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            data_q  <= data_d;
            word_q  <= word_d;
        end
    end

    // The RAM returns each byte one cycle after its address, so byte n lands when cnt = n+1.
    // Any loss of grant or ready restarts the whole word because the byte pipeline cannot resume.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        data_d  = data_q;
        word_d  = word_q;

        if (bus.flush_in) begin
            state_d = IFR_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IFR_IDLE: begin
                    if (bus.miss_valid_in && bus.rdy_in) begin
                        base_d  = bus.miss_addr_in & ~ADDR_W'(3);
                        state_d = IFR_REQ;
                    end
                end
                IFR_REQ: begin
                    cnt_d = '0;
                    if (bus.rdy_in && bus.mem_gnt_in) begin
                        state_d = IFR_READ;
                    end
                end
                IFR_READ: begin
                    if (!bus.rdy_in || !bus.mem_gnt_in) begin
                        state_d = IFR_REQ;
                        cnt_d   = '0;
                    end else begin
                        case (cnt_q)
                            3'd1:    data_d[7:0]   = bus.mem_din;
                            3'd2:    data_d[15:8]  = bus.mem_din;
                            3'd3:    data_d[23:16] = bus.mem_din;
                            3'd4:    data_d[31:24] = bus.mem_din;
                            default: ;
                        endcase
                        if (cnt_q == CNT_LAST) begin
                            state_d = IFR_WB;
                            cnt_d   = '0;
                            word_d  = data_d;
                        end else begin
                            cnt_d = cnt_q + IFR_CNT_W'(1);
                        end
                    end
                end
                IFR_WB: begin
                    if (bus.rdy_in) begin
                        state_d = IFR_IDLE;
                    end
                end
                default: state_d = IFR_IDLE;
            endcase
        end
    end

    // The write pulse is gated combinationally so a late flush or a ready drop still cancels it.
    always_comb begin
        memReq   = 1'b0;
        memA     = '0;
        refillWe = 1'b0;
        unique case (state_q)
            IFR_REQ: begin
                memReq = 1'b1;
            end
            IFR_READ: begin
                memReq = 1'b1;
                memA   = base_q + ADDR_W'(byteOffset(cnt_q));
            end
            IFR_WB: begin
                refillWe = !bus.flush_in && bus.rdy_in;
            end
            default: ;
        endcase
    end

    assign bus.mem_req_out     = memReq;
    assign bus.mem_a           = memA;
    assign bus.mem_wr          = 1'b0;
    assign bus.refill_data_out = word_q;
    assign bus.refill_we_out   = refillWe;
    assign bus.busy_out        = (state_q != IFR_IDLE);

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl: a per-cycle vector table plus hand-written
// sequences for reset, flush, grant-drop and ready-drop corner cases.
module tb_icache_refill_ctrl;
    import icache_refill_ctrl_pkg::*;

    typedef struct {
        logic        rstN;
        logic        miss;
        logic [31:0] addr;
        logic        flush;
        logic        gnt;
        logic        rdy;
        logic        expReq;
        logic [31:0] expA;
        logic        expWe;
        logic [31:0] expData;
        logic        expBusy;
    } vec_t;

    logic        clock = 1'b0;
    logic        rstN;
    logic [7:0]  memDin = 8'h00;
    logic [31:0] aSample = '0;
    int          checkCount = 0;
    int          passCount = 0;
    vec_t        vecs[$];

    icache_refill_ctrl_if ifc ();

    icache_refill_ctrl dut (
        .clk_in (clock),
        .rst_in (rstN),
        .bus    (ifc)
    );

    always #5 clock = ~clock;

    assign ifc.mem_din = memDin;

    function automatic logic [7:0] ramByte(input logic [31:0] a);
        case (a)
            32'h0000_1004: return 8'h13;
            32'h0000_1005: return 8'h00;
            32'h0000_1006: return 8'h05;
            32'h0000_1007: return 8'h93;
            32'hFFFF_FFFC: return 8'hAA;
            32'hFFFF_FFFD: return 8'hBB;
            32'hFFFF_FFFE: return 8'hCC;
            32'hFFFF_FFFF: return 8'hDD;
            default:       return a[7:0] ^ 8'h5A;
        endcase
    endfunction

    // RAM model: data for the address seen in one cycle appears in the next.
    always begin
        @(negedge clock);
        aSample = ifc.mem_a;
        @(posedge clock);
        #1 memDin = ramByte(aSample);
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic setInputs(input logic miss, input logic [31:0] addr, input logic flush,
                             input logic gnt, input logic rdy);
        ifc.miss_valid_in = miss;
        ifc.miss_addr_in  = addr;
        ifc.flush_in      = flush;
        ifc.mem_gnt_in    = gnt;
        ifc.rdy_in        = rdy;
    endtask

    task automatic applyStimulus(input vec_t v);
        rstN = v.rstN;
        setInputs(v.miss, v.addr, v.flush, v.gnt, v.rdy);
    endtask

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic addVec(input logic rN, input logic miss, input logic [31:0] addr, input logic flush,
                          input logic gnt, input logic rdy, input logic eReq, input logic [31:0] eA,
                          input logic eWe, input logic [31:0] eData, input logic eBusy);
        vec_t v;
        v.rstN = rN; v.miss = miss; v.addr = addr; v.flush = flush; v.gnt = gnt; v.rdy = rdy;
        v.expReq = eReq; v.expA = eA; v.expWe = eWe; v.expData = eData; v.expBusy = eBusy;
        vecs.push_back(v);
    endtask

    task automatic checkAll(input string tag, input logic eReq, input logic [31:0] eA, input logic eWe,
                            input logic [31:0] eData, input logic eBusy);
        checkOutput({tag, ".memReq"}, 32'(ifc.mem_req_out), 32'(eReq));
        checkOutput({tag, ".memA"}, ifc.mem_a, eA);
        checkOutput({tag, ".refillWe"}, 32'(ifc.refill_we_out), 32'(eWe));
        checkOutput({tag, ".refillData"}, ifc.refill_data_out, eData);
        checkOutput({tag, ".busy"}, 32'(ifc.busy_out), 32'(eBusy));
        checkOutput({tag, ".memWr"}, 32'(ifc.mem_wr), 32'd0);
    endtask

    initial begin
        logic        weSeen;
        int          weAt;
        int          weCount;
        logic [31:0] weData;

        rstN = 1'b0;
        setInputs(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

        // Reset, then a full refill of 0x1006 with grant held high.
        addVec(0, 0, 32'h0,         0, 1, 1,  0, 32'h0,         0, 32'h0,         0);
        addVec(1, 1, 32'h0000_1006, 0, 1, 1,  0, 32'h0,         0, 32'h0,         0);
        addVec(1, 0, 32'h0,         0, 1, 1,  1, 32'h0,         0, 32'h0,         1);
        addVec(1, 0, 32'h0,         0, 1, 1,  1, 32'h0000_1004, 0, 32'h0,         1);
        addVec(1, 0, 32'h0,         0, 1, 1,  1, 32'h0000_1005, 0, 32'h0,         1);
        addVec(1, 0, 32'h0,         0, 1, 1,  1, 32'h0000_1006, 0, 32'h0,         1);
        addVec(1, 0, 32'h0,         0, 1, 1,  1, 32'h0000_1007, 0, 32'h0,         1);
        addVec(1, 0, 32'h0,         0, 1, 1,  1, 32'h0000_1007, 0, 32'h0,         1);
        addVec(1, 0, 32'h0,         0, 1, 1,  0, 32'h0,         1, 32'h9305_0013, 1);
        addVec(1, 0, 32'h0,         0, 1, 1,  0, 32'h0,         0, 32'h9305_0013, 0);
        // Top-of-memory word: addresses must not wrap past 0xFFFF_FFFF.
        addVec(1, 1, 32'hFFFF_FFFF, 0, 1, 1,  0, 32'h0,         0, 32'h9305_0013, 0);
        addVec(1, 0, 32'h0,         0, 1, 1,  1, 32'h0,         0, 32'h9305_0013, 1);
        addVec(1, 0, 32'h0,         0, 1, 1,  1, 32'hFFFF_FFFC, 0, 32'h9305_0013, 1);
        addVec(1, 0, 32'h0,         0, 1, 1,  1, 32'hFFFF_FFFD, 0, 32'h9305_0013, 1);
        addVec(1, 0, 32'h0,         0, 1, 1,  1, 32'hFFFF_FFFE, 0, 32'h9305_0013, 1);
        addVec(1, 0, 32'h0,         0, 1, 1,  1, 32'hFFFF_FFFF, 0, 32'h9305_0013, 1);
        addVec(1, 0, 32'h0,         0, 1, 1,  1, 32'hFFFF_FFFF, 0, 32'h9305_0013, 1);
        addVec(1, 0, 32'h0,         0, 1, 1,  0, 32'h0,         1, 32'hDDCC_BBAA, 1);
        addVec(1, 0, 32'h0,         0, 1, 1,  0, 32'h0,         0, 32'hDDCC_BBAA, 0);
        // Grant withheld for three REQ cycles: pulse arrives three cycles later.
        addVec(1, 1, 32'h0000_1004, 0, 0, 1,  0, 32'h0,         0, 32'hDDCC_BBAA, 0);
        addVec(1, 0, 32'h0,         0, 0, 1,  1, 32'h0,         0, 32'hDDCC_BBAA, 1);
        addVec(1, 0, 32'h0,         0, 0, 1,  1, 32'h0,         0, 32'hDDCC_BBAA, 1);
        addVec(1, 0, 32'h0,         0, 0, 1,  1, 32'h0,         0, 32'hDDCC_BBAA, 1);
        addVec(1, 0, 32'h0,         0, 1, 1,  1, 32'h0,         0, 32'hDDCC_BBAA, 1);
        addVec(1, 0, 32'h0,         0, 1, 1,  1, 32'h0000_1004, 0, 32'hDDCC_BBAA, 1);
        addVec(1, 0, 32'h0,         0, 1, 1,  1, 32'h0000_1005, 0, 32'hDDCC_BBAA, 1);
        addVec(1, 0, 32'h0,         0, 1, 1,  1, 32'h0000_1006, 0, 32'hDDCC_BBAA, 1);
        addVec(1, 0, 32'h0,         0, 1, 1,  1, 32'h0000_1007, 0, 32'hDDCC_BBAA, 1);
        addVec(1, 0, 32'h0,         0, 1, 1,  1, 32'h0000_1007, 0, 32'hDDCC_BBAA, 1);
        addVec(1, 0, 32'h0,         0, 1, 1,  0, 32'h0,         1, 32'h9305_0013, 1);
        addVec(1, 0, 32'h0,         0, 1, 1,  0, 32'h0,         0, 32'h9305_0013, 0);
        // Flush and miss together in IDLE: the miss must be dropped.
        addVec(1, 1, 32'h0000_1004, 1, 1, 1,  0, 32'h0,         0, 32'h9305_0013, 0);
        addVec(1, 0, 32'h0,         0, 1, 1,  0, 32'h0,         0, 32'h9305_0013, 0);

        foreach (vecs[i]) begin
            nextCycle();
            applyStimulus(vecs[i]);
            @(negedge clock);
            checkAll($sformatf("vec%0d", i), vecs[i].expReq, vecs[i].expA, vecs[i].expWe,
                     vecs[i].expData, vecs[i].expBusy);
        end

        // Asynchronous reset while in READ with cnt=2.
        nextCycle(); setInputs(1, 32'h0000_3000, 0, 1, 1);
        nextCycle(); setInputs(0, 32'h0, 0, 1, 1);
        repeat (3) nextCycle();
        @(negedge clock);
        checkOutput("rstMid.preA", ifc.mem_a, 32'h0000_3002);
        #2 rstN = 1'b0;
        #1 checkAll("rstMid", 0, 32'h0, 0, 32'h0, 0);
        nextCycle(); rstN = 1'b1;
        @(negedge clock);
        checkOutput("rstMid.afterBusy", 32'(ifc.busy_out), 32'd0);

        // Flush in READ (cnt=2): no write may follow.
        nextCycle(); setInputs(1, 32'h0000_1004, 0, 1, 1);
        nextCycle(); setInputs(0, 32'h0, 0, 1, 1);
        repeat (2) nextCycle();
        nextCycle(); ifc.flush_in = 1'b1;
        @(negedge clock);
        checkOutput("flushRead.cntA", ifc.mem_a, 32'h0000_1006);
        nextCycle(); ifc.flush_in = 1'b0;
        @(negedge clock);
        checkOutput("flushRead.busy", 32'(ifc.busy_out), 32'd0);
        checkOutput("flushRead.req", 32'(ifc.mem_req_out), 32'd0);
        weCount = 0;
        for (int k = 0; k < 8; k++) begin
            nextCycle();
            @(negedge clock);
            if (ifc.refill_we_out) weCount++;
        end
        checkOutput("flushRead.pulses", 32'(weCount), 32'd0);

        // Flush during WB: the pulse is cancelled in that very cycle.
        nextCycle(); setInputs(1, 32'h0000_1004, 0, 1, 1);
        nextCycle(); setInputs(0, 32'h0, 0, 1, 1);
        repeat (5) nextCycle();
        nextCycle(); ifc.flush_in = 1'b1;
        @(negedge clock);
        checkOutput("flushWb.we", 32'(ifc.refill_we_out), 32'd0);
        checkOutput("flushWb.busy", 32'(ifc.busy_out), 32'd1);
        nextCycle(); ifc.flush_in = 1'b0;
        @(negedge clock);
        checkOutput("flushWb.afterBusy", 32'(ifc.busy_out), 32'd0);

        // Grant lost at cnt=3 and returned two cycles later: word is re-read from base.
        nextCycle(); setInputs(1, 32'h0000_2000, 0, 1, 1);
        nextCycle(); setInputs(0, 32'h0, 0, 1, 1);
        repeat (3) nextCycle();
        nextCycle(); ifc.mem_gnt_in = 1'b0;
        @(negedge clock);
        checkOutput("gntDrop.cnt3A", ifc.mem_a, 32'h0000_2003);
        nextCycle();
        @(negedge clock);
        checkOutput("gntDrop.waitReq", 32'(ifc.mem_req_out), 32'd1);
        checkOutput("gntDrop.waitA", ifc.mem_a, 32'h0);
        nextCycle(); ifc.mem_gnt_in = 1'b1;
        nextCycle();
        @(negedge clock);
        checkOutput("gntDrop.restartA", ifc.mem_a, 32'h0000_2000);
        weSeen = 1'b0;
        weAt = 0;
        weData = '0;
        for (int k = 1; k <= 12 && !weSeen; k++) begin
            nextCycle();
            @(negedge clock);
            if (ifc.refill_we_out) begin
                weSeen = 1'b1;
                weAt = k;
                weData = ifc.refill_data_out;
            end
        end
        checkOutput("gntDrop.weSeen", 32'(weSeen), 32'd1);
        checkOutput("gntDrop.weCycle", 32'(weAt), 32'd5);
        checkOutput("gntDrop.data", weData, 32'h5958_5B5A);

        // Ready low in READ restarts from REQ; ready low in WB holds the pulse back.
        nextCycle(); setInputs(1, 32'h0000_1004, 0, 1, 1);
        nextCycle(); setInputs(0, 32'h0, 0, 1, 1);
        repeat (2) nextCycle();
        nextCycle(); ifc.rdy_in = 1'b0;
        nextCycle(); ifc.rdy_in = 1'b1;
        @(negedge clock);
        checkOutput("rdyRead.req", 32'(ifc.mem_req_out), 32'd1);
        checkOutput("rdyRead.a", ifc.mem_a, 32'h0);
        repeat (5) nextCycle();
        nextCycle(); ifc.rdy_in = 1'b0;
        @(negedge clock);
        checkAll("rdyWb.hold1", 0, 32'h0, 0, 32'h9305_0013, 1);
        nextCycle();
        @(negedge clock);
        checkAll("rdyWb.hold2", 0, 32'h0, 0, 32'h9305_0013, 1);
        nextCycle(); ifc.rdy_in = 1'b1;
        @(negedge clock);
        checkAll("rdyWb.release", 0, 32'h0, 1, 32'h9305_0013, 1);
        nextCycle();
        @(negedge clock);
        checkAll("rdyWb.idle", 0, 32'h0, 0, 32'h9305_0013, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
